// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 width codes,
// FSM states and the small decode helpers used at the accept edge.
package load_store_unit_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } lsu_state_e;

   function automatic logic width_illegal(input logic [6:0] opc, input logic [2:0] f3);
      logic ill;
      ill = 1'b1;
      if (opc == OPC_LOAD) begin
         ill = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      end else if (opc == OPC_STORE) begin
         ill = !(f3 inside {F3_B, F3_H, F3_W});
      end
      return ill;
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_H, F3_HU: mis = a[0];
         F3_W:        mis = (a != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] s;
      case (f3)
         F3_B:    s = 4'b0001 << a;
         F3_H:    s = 4'b0011 << a;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      case (f3)
         F3_B:    w = {4{sd[7:0]}};
         F3_H:    w = {2{sd[15:0]}};
         default: w = sd;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// mem_req is held high until the cycle mem_ack=1 is sampled (or the master gives
// up on timeout); mem_ack and mem_rdata are meaningful only while mem_req=1.
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/load_store_unit_load_data_aligner.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_data_aligner
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] load_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_data_o = {24'h000000, byte_sel};
         F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_data_o = {16'h0000, half_sel};
         default: load_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per accepted LOAD/STORE,
// with byte strobes, load extension, and misaligned/illegal/timeout reporting.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic [31:0]        address,
   input  logic [31:0]        store_data,
   output logic               busy,
   output logic               done,
   output logic [31:0]        load_data,
   output logic               misaligned,
   output logic               illegal_width,
   output logic               bus_error,
   load_store_unit_if.master  mem,
   output lsu_state_e         dbg_state_o
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic        we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;
   logic [31:0] load_data_q;
   logic        illegal_q;
   logic        misal_q;
   logic        timeout_q;

   logic        op_valid;
   logic        dec_illegal;
   logic        dec_misal;
   logic        is_store;
   logic        accept;
   logic        timeout_hit;
   logic [31:0] aligned_data;

   assign op_valid    = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
   assign is_store    = (opcode == OPC_STORE);
   assign dec_illegal = width_illegal(opcode, funct3);
   assign dec_misal   = addr_misaligned(funct3, address[1:0]);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && op_valid) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = (dec_illegal || dec_misal) ? ST_ERR : ST_REQ;
            end
         end
         ST_REQ: begin
            // An ack on the last counted cycle still completes normally.
            if (mem.mem_ack) begin
               state_d = ST_DONE;
            end else if (TIMEOUT_CYCLES != 0) begin
               if (cnt_q == CNT_LAST) begin
                  state_d     = ST_ERR;
                  timeout_hit = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         funct3_q    <= 3'b000;
         addr_lo_q   <= 2'b00;
         we_q        <= 1'b0;
         mem_addr_q  <= 32'h0;
         wstrb_q     <= 4'h0;
         wdata_q     <= 32'h0;
         load_data_q <= 32'h0;
         illegal_q   <= 1'b0;
         misal_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            funct3_q   <= funct3;
            addr_lo_q  <= address[1:0];
            we_q       <= is_store;
            mem_addr_q <= {address[31:2], 2'b00};
            wstrb_q    <= is_store ? store_strobe(funct3, address[1:0]) : 4'h0;
            wdata_q    <= is_store ? store_wdata(funct3, store_data) : 32'h0;
            illegal_q  <= dec_illegal;
            misal_q    <= dec_misal && !dec_illegal;
            timeout_q  <= 1'b0;
         end
         if (timeout_hit) begin
            timeout_q <= 1'b1;
         end
         if ((state_q == ST_REQ) && mem.mem_ack && !we_q) begin
            load_data_q <= aligned_data;
         end
      end
   end

   load_data_aligner u_aligner (
      .rdata_i     (mem.mem_rdata),
      .addr_lo_i   (addr_lo_q),
      .funct3_i    (funct3_q),
      .load_data_o (aligned_data)
   );

   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign load_data     = load_data_q;
   assign misaligned    = (state_q == ST_ERR) && misal_q;
   assign illegal_width = (state_q == ST_ERR) && illegal_q;
   assign bus_error     = (state_q == ST_ERR) && timeout_q;
   assign dbg_state_o   = state_q;

   assign mem.mem_req   = (state_q == ST_REQ);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wstrb = wstrb_q;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error ops, timeout and reset.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic        illegal_width;
   logic        bus_error;
   lsu_state_e  dbg_state;

   load_store_unit_if mem_bus ();

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_load;
   logic [31:0] exp_v;

   // {busy, done, mem_req, misaligned, illegal_width, bus_error}
   logic [5:0] ctl;
   assign ctl = {busy, done, mem_bus.mem_req, misaligned, illegal_width, bus_error};

   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_REQ  = 6'b101000;
   localparam logic [5:0] C_OK   = 6'b110000;
   localparam logic [5:0] C_MIS  = 6'b110100;
   localparam logic [5:0] C_ILL  = 6'b110010;
   localparam logic [5:0] C_BUS  = 6'b110001;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .opcode        (opcode),
      .funct3        (funct3),
      .address       (address),
      .store_data    (store_data),
      .busy          (busy),
      .done          (done),
      .load_data     (load_data),
      .misaligned    (misaligned),
      .illegal_width (illegal_width),
      .bus_error     (bus_error),
      .mem           (mem_bus.master),
      .dbg_state_o   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      start = 1'b1; opcode = opc; funct3 = f3; address = a; store_data = sd;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      n_tests++;
      if (ctl !== C_IDLE) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE); end
      n_tests++;
      if ({load_data, mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_wdata, mem_bus.mem_we} !== 101'd0) begin
         n_fail++; $display("FAIL reset_data: load_data %h addr %h wstrb %b wdata %h we %b want all 0",
                            load_data, mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_wdata, mem_bus.mem_we);
      end
      n_tests++;
      if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
      reset = 1'b0;
      step();
      n_tests++;
      if (ctl !== C_IDLE) begin n_fail++; $display("FAIL post_reset_ctl: got %b want %b", ctl, C_IDLE); end
      last_load = 32'h0;
   endtask

   task automatic test_lw();
      issue(OPC_LOAD, F3_W, 32'h0000_0100, 32'h0);
      n_tests++;
      if (ctl !== C_REQ) begin n_fail++; $display("FAIL lw_c1_ctl: got %b want %b", ctl, C_REQ); end
      n_tests++;
      if ({mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_we} !== {32'h100, 4'b0000, 1'b0}) begin
         n_fail++; $display("FAIL lw_bus: addr %h wstrb %b we %b want 00000100 0000 0",
                            mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_we);
      end
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
      exp_q.push_back(32'hDEAD_BEEF);
      step();
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
      n_tests++;
      if (ctl !== C_OK) begin n_fail++; $display("FAIL lw_c2_ctl: got %b want %b", ctl, C_OK); end
      exp_v = exp_q.pop_front();
      n_tests++;
      if (load_data !== exp_v) begin n_fail++; $display("FAIL lw_data: got %h want %h", load_data, exp_v); end
      last_load = exp_v;
      step();
      n_tests++;
      if ({ctl, load_data} !== {C_IDLE, last_load}) begin
         n_fail++; $display("FAIL lw_hold: ctl %b data %h want %b %h", ctl, load_data, C_IDLE, last_load);
      end
   endtask

   localparam logic [2:0]  LX_F3   [7] = '{F3_B, F3_BU, F3_HU, F3_H, F3_B, F3_H, F3_BU};
   localparam logic [31:0] LX_ADDR [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101};
   localparam logic [31:0] LX_RD   [7] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233,
                                           32'h80112233, 32'h0000F00D, 32'h80112233};
   localparam logic [31:0] LX_EXP  [7] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011,
                                           32'h00000033, 32'hFFFFF00D, 32'h00000022};
   localparam int          LX_WAIT [7] = '{0, 1, 2, 0, 0, 3, 1};

   task automatic test_load_ext();
      for (int i = 0; i < 7; i++) begin
         issue(OPC_LOAD, LX_F3[i], LX_ADDR[i], 32'h0);
         exp_q.push_back(LX_EXP[i]);
         for (int w = 0; w < LX_WAIT[i]; w++) begin
            mem_bus.mem_rdata = 32'h5A5A_5A5A;
            n_tests++;
            if (ctl !== C_REQ) begin n_fail++; $display("FAIL ld_ext[%0d] wait_ctl: got %b want %b", i, ctl, C_REQ); end
            step();
         end
         mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = LX_RD[i];
         step();
         mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
         n_tests++;
         if (ctl !== C_OK) begin n_fail++; $display("FAIL ld_ext[%0d] done_ctl: got %b want %b", i, ctl, C_OK); end
         exp_v = exp_q.pop_front();
         n_tests++;
         if (load_data !== exp_v) begin n_fail++; $display("FAIL ld_ext[%0d] data: got %h want %h", i, load_data, exp_v); end
         last_load = exp_v;
         step();
      end
   endtask

   localparam logic [2:0]  ST_F3   [5] = '{F3_H, F3_B, F3_W, F3_B, F3_H};
   localparam logic [31:0] ST_ADDR [5] = '{32'h206, 32'h201, 32'h300, 32'h003, 32'h200};
   localparam logic [31:0] ST_SD   [5] = '{32'h0000ABCD, 32'h12345678, 32'hCAFEF00D, 32'h000000A5, 32'h1234BEEF};
   localparam logic [31:0] ST_EADR [5] = '{32'h204, 32'h200, 32'h300, 32'h000, 32'h200};
   localparam logic [3:0]  ST_ESTB [5] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000, 4'b0011};
   localparam logic [31:0] ST_EWD  [5] = '{32'hABCDABCD, 32'h78787878, 32'hCAFEF00D, 32'hA5A5A5A5, 32'hBEEFBEEF};

   task automatic test_store();
      for (int i = 0; i < 5; i++) begin
         issue(OPC_STORE, ST_F3[i], ST_ADDR[i], ST_SD[i]);
         n_tests++;
         if ({ctl, mem_bus.mem_we} !== {C_REQ, 1'b1}) begin
            n_fail++; $display("FAIL st[%0d] ctl_we: got %b %b want %b 1", i, ctl, mem_bus.mem_we, C_REQ);
         end
         n_tests++;
         if ({mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_wdata} !== {ST_EADR[i], ST_ESTB[i], ST_EWD[i]}) begin
            n_fail++; $display("FAIL st[%0d] bus: addr %h wstrb %b wdata %h want %h %b %h", i,
                               mem_bus.mem_addr, mem_bus.mem_wstrb, mem_bus.mem_wdata, ST_EADR[i], ST_ESTB[i], ST_EWD[i]);
         end
         mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFF_FFFF;
         step();
         mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
         n_tests++;
         if ({ctl, load_data} !== {C_OK, last_load}) begin
            n_fail++; $display("FAIL st[%0d] done: ctl %b data %h want %b %h", i, ctl, load_data, C_OK, last_load);
         end
         step();
      end
   endtask

   localparam logic [6:0]  ER_OPC  [7] = '{OPC_LOAD, OPC_LOAD, OPC_STORE, OPC_LOAD, OPC_STORE, OPC_LOAD, OPC_STORE};
   localparam logic [2:0]  ER_F3   [7] = '{F3_W, 3'b011, F3_HU, F3_H, F3_W, 3'b110, F3_BU};
   localparam logic [31:0] ER_ADDR [7] = '{32'h101, 32'h100, 32'h101, 32'h103, 32'h302, 32'h100, 32'h000};
   localparam logic [5:0]  ER_CTL  [7] = '{C_MIS, C_ILL, C_ILL, C_MIS, C_MIS, C_ILL, C_ILL};

   task automatic test_errors();
      for (int i = 0; i < 7; i++) begin
         issue(ER_OPC[i], ER_F3[i], ER_ADDR[i], 32'h1111_2222);
         n_tests++;
         if (ctl !== ER_CTL[i]) begin n_fail++; $display("FAIL err[%0d] c1_ctl: got %b want %b", i, ctl, ER_CTL[i]); end
         step();
         n_tests++;
         if ({ctl, load_data} !== {C_IDLE, last_load}) begin
            n_fail++; $display("FAIL err[%0d] c2: ctl %b data %h want %b %h", i, ctl, load_data, C_IDLE, last_load);
         end
      end
   endtask

   task automatic test_timeout();
      int req_cycles;
      req_cycles = 0;
      issue(OPC_LOAD, F3_W, 32'h100, 32'h0);
      for (int g = 0; g < 20 && done !== 1'b1; g++) begin
         if (mem_bus.mem_req === 1'b1) req_cycles++;
         step();
      end
      n_tests++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL timeout_bound: done never rose within 20 cycles"); end
      n_tests++;
      if (req_cycles != 4) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 4", req_cycles); end
      n_tests++;
      if ({ctl, load_data} !== {C_BUS, last_load}) begin
         n_fail++; $display("FAIL timeout_done: ctl %b data %h want %b %h", ctl, load_data, C_BUS, last_load);
      end
      step();
      n_tests++;
      if (ctl !== C_IDLE) begin n_fail++; $display("FAIL timeout_idle: got %b want %b", ctl, C_IDLE); end

      issue(OPC_LOAD, F3_W, 32'h100, 32'h0);
      step(); step(); step();
      n_tests++;
      if (ctl !== C_REQ) begin n_fail++; $display("FAIL ack_last_c4: got %b want %b", ctl, C_REQ); end
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h0BAD_F00D;
      step();
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
      n_tests++;
      if ({ctl, load_data} !== {C_OK, 32'h0BAD_F00D}) begin
         n_fail++; $display("FAIL ack_last_done: ctl %b data %h want %b 0badf00d", ctl, load_data, C_OK);
      end
      last_load = 32'h0BAD_F00D;
      step();
   endtask

   task automatic test_reset_mid();
      issue(OPC_LOAD, F3_W, 32'h100, 32'h0);
      step();
      n_tests++;
      if (ctl !== C_REQ) begin n_fail++; $display("FAIL rst_mid_c2: got %b want %b", ctl, C_REQ); end
      reset = 1'b1; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h1111_1111;
      step();
      reset = 1'b0; mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
      n_tests++;
      if ({ctl, load_data} !== {C_IDLE, 32'h0}) begin
         n_fail++; $display("FAIL rst_mid_edge: ctl %b data %h want %b 00000000", ctl, load_data, C_IDLE);
      end
      last_load = 32'h0;
      step();
      n_tests++;
      if (ctl !== C_IDLE) begin n_fail++; $display("FAIL rst_mid_no_done: got %b want %b", ctl, C_IDLE); end
   endtask

   task automatic test_busy_ignore();
      issue(OPC_LOAD, F3_W, 32'h104, 32'h0);
      start = 1'b1; opcode = OPC_STORE; funct3 = F3_W; address = 32'h300; store_data = 32'hFFFF_0000;
      step();
      n_tests++;
      if ({ctl, mem_bus.mem_we, mem_bus.mem_addr} !== {C_REQ, 1'b0, 32'h104}) begin
         n_fail++; $display("FAIL busy_c2: ctl %b we %b addr %h want %b 0 00000104", ctl, mem_bus.mem_we, mem_bus.mem_addr, C_REQ);
      end
      mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h7654_3210;
      step();
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
      n_tests++;
      if ({ctl, load_data} !== {C_OK, 32'h7654_3210}) begin
         n_fail++; $display("FAIL busy_done: ctl %b data %h want %b 76543210", ctl, load_data, C_OK);
      end
      last_load = 32'h7654_3210;
      step();
      start = 1'b0;
      n_tests++;
      if (ctl !== C_IDLE) begin n_fail++; $display("FAIL busy_no_accept: got %b want %b", ctl, C_IDLE); end
      start = 1'b1; opcode = 7'b0110011; funct3 = F3_W; address = 32'h100;
      step();
      start = 1'b0;
      n_tests++;
      if ({ctl, dbg_state} !== {C_IDLE, ST_IDLE}) begin
         n_fail++; $display("FAIL other_opcode: ctl %b state %0d want %b %0d", ctl, dbg_state, C_IDLE, ST_IDLE);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; address = 32'h0; store_data = 32'h0;
      mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
      last_load = 32'h0;
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_busy_ignore();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
